// File: rtl/onchip_sample_writer.sv
// Purpose: captures a 16-bit sample stream into single-port on-chip RAM (one-shot or circular);
//          ONCHIP_SAMPLE_PACK_EN packs two samples per 32-bit word, otherwise one sample per word.
// Latency: a word is written the cycle after its last sample is accepted; backpressure: s_ready=1 only while filling.
module onchip_sample_writer #(
  parameter int DEPTH  = 12000,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              circ,
  input  logic              s_valid,
  input  logic [15:0]       s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic              avm_clken,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] wr_count
);

  typedef enum logic [1:0] {IDLE, FILL, FLUSH, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] FULL_CNT  = ADDR_W'(DEPTH);

  state_t            state, state_nxt;
  logic              circ_q, tail, wr, ovf;
  logic [ADDR_W-1:0] addr, cnt, word_addr;
  logic [31:0]       wdat, full_dat, sched_dat;
  logic [3:0]        wbe, full_be, sched_be;
  logic              go, accept, word_done, word_last, closing, half_keep, sched;

`ifdef ONCHIP_SAMPLE_PACK_EN
  logic              half_vld;
  logic [15:0]       half_dat;
`endif

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  // tail marks the final write cycle of a capture: still FILL, but no longer accepting
  assign go      = start && (state == IDLE || state == DONE);
  assign s_ready = (state == FILL) && !tail;
  assign accept  = s_ready && s_valid;

`ifdef ONCHIP_SAMPLE_PACK_EN
  assign word_done = accept && half_vld;
  assign half_keep = half_vld ? !accept : accept;
  assign full_dat  = {s_data, half_dat};
  assign full_be   = 4'b1111;
`else
  assign word_done = accept;
  assign half_keep = 1'b0;
  assign full_dat  = {16'h0000, s_data};
  assign full_be   = 4'b0011;
`endif

  // a write in flight this cycle bumps the address, so the word completing now lands one further on
  assign word_addr = wr ? addr_inc(addr) : addr;
  assign word_last = word_done && !circ_q && (word_addr == LAST_ADDR);
  assign closing   = s_ready && (stop || word_last);

  // select what (if anything) is written next cycle: a completed word or, on stop, the lone half
  always_comb begin
    sched     = word_done;
    sched_dat = full_dat;
    sched_be  = full_be;
`ifdef ONCHIP_SAMPLE_PACK_EN
    if (closing && half_keep) begin
      sched     = 1'b1;
      sched_dat = {16'h0000, (half_vld ? half_dat : s_data)};
      sched_be  = 4'b0011;
    end
`endif
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next-state: FLUSH only when a half word must be written out on stop
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = FILL;
      FILL: begin
        if (tail)                   state_nxt = DONE;
        else if (closing) begin
          if (half_keep)            state_nxt = FLUSH;
          else if (!word_done)      state_nxt = DONE;
        end
      end
      FLUSH:                        state_nxt = DONE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // write port, address/count tracking and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      circ_q <= 1'b0;
      tail   <= 1'b0;
      wr     <= 1'b0;
      wdat   <= '0;
      wbe    <= '0;
      addr   <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      wr <= sched;
      if (sched) begin
        wdat <= sched_dat;
        wbe  <= sched_be;
      end
      if (go) begin
        circ_q <= circ;
        tail   <= 1'b0;
        addr   <= '0;
        cnt    <= '0;
        ovf    <= 1'b0;
      end else begin
        if (closing && word_done) tail <= 1'b1;
        if (wr) begin
          addr <= addr_inc(addr);
          if (cnt != FULL_CNT) cnt <= cnt + ADDR_W'(1);
        end
        if (s_valid && (state == FLUSH || state == DONE)) ovf <= 1'b1;
      end
    end
  end

`ifdef ONCHIP_SAMPLE_PACK_EN
  // low-half holding register; cleared on start so a new capture never inherits a stale half
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      half_vld <= 1'b0;
      half_dat <= '0;
    end else if (go) begin
      half_vld <= 1'b0;
    end else if (accept) begin
      half_vld <= !half_vld && !closing;
      if (!half_vld) half_dat <= s_data;
    end else if (closing) begin
      half_vld <= 1'b0;
    end
  end
`endif

  assign avm_address    = addr;
  assign avm_byteenable = wbe;
  assign avm_chipselect = wr;
  assign avm_write      = wr;
  assign avm_writedata  = wdat;
  assign avm_clken      = reset_n;
  assign busy           = (state == FILL) || (state == FLUSH);
  assign done           = (state == DONE);
  assign overflow       = ovf;
  assign wr_count       = cnt;

endmodule

// File: tb/tb_onchip_sample_writer.sv
// Bench for onchip_sample_writer: random sample streams against a queue-based capture model.
// Inputs are driven 1 time unit after the rising edge; DUT outputs are sampled on the falling edge.
// Checks reset, one-shot, stop cases, circular wrap, overflow, mid-capture reset and back-to-back runs.
module tb_onchip_sample_writer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 4;
`ifdef ONCHIP_SAMPLE_PACK_EN
  localparam int SPW = 2;
`else
  localparam int SPW = 1;
`endif

  logic              clk, reset_n, start, stop, circ, s_valid, s_ready;
  logic [15:0]       s_data;
  logic [ADDR_W-1:0] avm_address, wr_count;
  logic [3:0]        avm_byteenable;
  logic              avm_chipselect, avm_write, avm_clken, busy, done, overflow;
  logic [31:0]       avm_writedata;

  onchip_sample_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .circ(circ),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_clken(avm_clken),
    .busy(busy), .done(done), .overflow(overflow), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // observed DUT activity
  logic [ADDR_W-1:0] w_addr[$];
  logic [31:0]       w_dat[$];
  logic [3:0]        w_be[$];
  int                dut_acc = 0;
  int                cs_bad = 0;

  // reference model: samples the capture should have taken, and expected writes
  logic [15:0]       m_acc[$];
  bit                m_active = 0;
  bit                m_circ = 0;
  logic [ADDR_W-1:0] e_addr[$];
  logic [31:0]       e_dat[$];
  logic [3:0]        e_be[$];

  always @(negedge clk) begin
    if (avm_write === 1'b1) begin
      w_addr.push_back(avm_address);
      w_dat.push_back(avm_writedata);
      w_be.push_back(avm_byteenable);
    end
    if (s_valid && s_ready) dut_acc++;
    if (avm_chipselect !== avm_write) cs_bad++;
  end

  // one clock of stimulus; the model decides acceptance from its own notion of capture activity
  task automatic drive(input bit v, input logic [15:0] d, input bit st, input bit sp, input bit c);
    bit do_start;
    s_valid = v; s_data = d; start = st; stop = sp; circ = c;
    do_start = st && !m_active;
    if (do_start) begin
      w_addr.delete(); w_dat.delete(); w_be.delete();
      dut_acc = 0;
    end
    @(negedge clk);
    if (m_active) begin
      if (v) m_acc.push_back(d);
      if (sp) m_active = 0;
      else if (!m_circ && m_acc.size() == DEPTH * SPW) m_active = 0;
    end else if (do_start) begin
      m_active = 1;
      m_circ = c;
      m_acc.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // memory image the model expects: sample pairs (or single samples), leftover half zero-extended
  function automatic void build_exp();
    e_addr.delete(); e_dat.delete(); e_be.delete();
    if (SPW == 2) begin
      for (int i = 0; i + 1 < m_acc.size(); i += 2) begin
        e_dat.push_back({m_acc[i+1], m_acc[i]});
        e_be.push_back(4'hF);
      end
      if (m_acc.size() % 2 == 1) begin
        e_dat.push_back({16'h0000, m_acc[m_acc.size()-1]});
        e_be.push_back(4'h3);
      end
    end else begin
      foreach (m_acc[i]) begin
        e_dat.push_back({16'h0000, m_acc[i]});
        e_be.push_back(4'h3);
      end
    end
    for (int k = 0; k < e_dat.size(); k++) e_addr.push_back(ADDR_W'(k % DEPTH));
  endfunction

  function automatic int exp_count();
    return (e_dat.size() < DEPTH) ? e_dat.size() : DEPTH;
  endfunction

  task automatic test_reset();
    reset_n = 0; start = 0; stop = 0; circ = 0; s_valid = 0; s_data = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s_ready, busy, done, overflow, avm_write, avm_chipselect, avm_clken,
         avm_byteenable, avm_address, wr_count, avm_writedata} !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero (ready=%b busy=%b clken=%b cnt=%0d) exp all 0",
                         s_ready, busy, avm_clken, wr_count);
    end
    reset_n = 1;
    @(posedge clk); #1;
    checks++;
    if (avm_clken !== 1'b1) begin errors++; $display("FAIL reset_clken got=%b exp=1", avm_clken); end
    for (int i = 0; i < 5; i++) drive(1, 16'($urandom), 0, 1, 0);
    checks++;
    if (w_addr.size() != 0 || s_ready !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_idle writes=%0d ready=%b done=%b exp 0/0/0", w_addr.size(), s_ready, done);
    end
  endtask

  task automatic test_oneshot();
    int n = 0;
    drive(0, 16'h0, 1, 0, 0);
    while (m_active && n < 200) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom), 0, 0, 0);
      n++;
    end
    checks++;
    if (m_active) begin errors++; $display("FAIL oneshot_budget capture still open after %0d cycles", n); end
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL oneshot_ready_drop got=%b exp=0", s_ready); end
    n = 0;
    while (done !== 1'b1 && n < 10) begin drive(0, 16'h0, 0, 0, 0); n++; end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL oneshot_done done=%b busy=%b exp 1/0", done, busy); end
    build_exp();
    checks++;
    if (w_addr.size() != e_addr.size()) begin errors++; $display("FAIL oneshot_nwr got=%0d exp=%0d", w_addr.size(), e_addr.size()); end
    for (int i = 0; i < e_addr.size() && i < w_addr.size(); i++) begin
      checks++;
      if ({w_addr[i], w_dat[i], w_be[i]} !== {e_addr[i], e_dat[i], e_be[i]}) begin
        errors++; $display("FAIL oneshot_wr%0d got a=%0d d=%h be=%b exp a=%0d d=%h be=%b",
                           i, w_addr[i], w_dat[i], w_be[i], e_addr[i], e_dat[i], e_be[i]);
      end
    end
    checks++;
    if (wr_count !== ADDR_W'(DEPTH) || dut_acc != m_acc.size() || overflow !== 1'b0) begin
      errors++; $display("FAIL oneshot_status cnt=%0d acc=%0d ovf=%b exp cnt=%0d acc=%0d ovf=0",
                         wr_count, dut_acc, overflow, DEPTH, m_acc.size());
    end
  endtask

  task automatic test_stop_mid_word();
    int n = 0;
    drive(0, 16'h0, 1, 0, 0);
    drive(1, 16'hAAAA, 0, 0, 0);
    drive(1, 16'hBBBB, 0, 0, 0);
    drive(1, 16'hCCCC, 0, 0, 0);
    drive(0, 16'h0, 0, 1, 0);
    while (done !== 1'b1 && n < 10) begin drive(0, 16'h0, 0, 0, 0); n++; end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL midword_done got=%b exp=1", done); end
    build_exp();
    checks++;
    if (w_addr.size() != e_addr.size()) begin errors++; $display("FAIL midword_nwr got=%0d exp=%0d", w_addr.size(), e_addr.size()); end
    for (int i = 0; i < e_addr.size() && i < w_addr.size(); i++) begin
      checks++;
      if ({w_addr[i], w_dat[i], w_be[i]} !== {e_addr[i], e_dat[i], e_be[i]}) begin
        errors++; $display("FAIL midword_wr%0d got a=%0d d=%h be=%b exp a=%0d d=%h be=%b",
                           i, w_addr[i], w_dat[i], w_be[i], e_addr[i], e_dat[i], e_be[i]);
      end
    end
  endtask

  task automatic test_stop_with_last();
    int n = 0;
    drive(0, 16'h0, 1, 0, 0);
    for (int i = 0; i < 2 * SPW - 1; i++) drive(1, 16'($urandom), 0, 0, 0);
    drive(1, 16'($urandom), 0, 1, 0);
    while (done !== 1'b1 && n < 10) begin drive(0, 16'h0, 0, 0, 0); n++; end
    build_exp();
    checks++;
    if (done !== 1'b1 || wr_count !== ADDR_W'(exp_count())) begin
      errors++; $display("FAIL stoplast_status done=%b cnt=%0d exp 1/%0d", done, wr_count, exp_count());
    end
    checks++;
    if (w_addr.size() != e_addr.size()) begin errors++; $display("FAIL stoplast_nwr got=%0d exp=%0d", w_addr.size(), e_addr.size()); end
    for (int i = 0; i < e_addr.size() && i < w_addr.size(); i++) begin
      checks++;
      if ({w_addr[i], w_dat[i], w_be[i]} !== {e_addr[i], e_dat[i], e_be[i]}) begin
        errors++; $display("FAIL stoplast_wr%0d got a=%0d d=%h be=%b exp a=%0d d=%h be=%b",
                           i, w_addr[i], w_dat[i], w_be[i], e_addr[i], e_dat[i], e_be[i]);
      end
    end
  endtask

  task automatic test_circular();
    int n = 0;
    drive(0, 16'h0, 1, 0, 1);
    while (m_acc.size() < 12 && n < 100) begin
      drive($urandom_range(0, 2) != 0, 16'($urandom), 0, 0, 0);
      n++;
    end
    checks++;
    if (m_acc.size() != 12 || dut_acc != 12) begin
      errors++; $display("FAIL circ_accepted model=%0d dut=%0d exp=12", m_acc.size(), dut_acc);
    end
    drive(0, 16'h0, 0, 1, 0);
    n = 0;
    while (done !== 1'b1 && n < 10) begin drive(0, 16'h0, 0, 0, 0); n++; end
    build_exp();
    checks++;
    if (done !== 1'b1 || wr_count !== ADDR_W'(DEPTH) || overflow !== 1'b0) begin
      errors++; $display("FAIL circ_status done=%b cnt=%0d ovf=%b exp 1/%0d/0", done, wr_count, overflow, DEPTH);
    end
    checks++;
    if (w_addr.size() != e_addr.size()) begin errors++; $display("FAIL circ_nwr got=%0d exp=%0d", w_addr.size(), e_addr.size()); end
    for (int i = 0; i < e_addr.size() && i < w_addr.size(); i++) begin
      checks++;
      if ({w_addr[i], w_dat[i], w_be[i]} !== {e_addr[i], e_dat[i], e_be[i]}) begin
        errors++; $display("FAIL circ_wr%0d got a=%0d d=%h be=%b exp a=%0d d=%h be=%b",
                           i, w_addr[i], w_dat[i], w_be[i], e_addr[i], e_dat[i], e_be[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int n = 0;
    drive(1, 16'($urandom), 0, 0, 0);
    drive(0, 16'h0, 0, 0, 0);
    drive(0, 16'h0, 0, 0, 0);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    drive(0, 16'h0, 1, 0, 0);
    checks++;
    if (overflow !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL ovf_clear ovf=%b done=%b busy=%b exp 0/0/1", overflow, done, busy);
    end
    drive(0, 16'h0, 0, 1, 0);
    while (done !== 1'b1 && n < 10) begin drive(0, 16'h0, 0, 0, 0); n++; end
    checks++;
    if (done !== 1'b1 || w_addr.size() != 0 || wr_count !== '0) begin
      errors++; $display("FAIL ovf_empty done=%b writes=%0d cnt=%0d exp 1/0/0", done, w_addr.size(), wr_count);
    end
  endtask

  task automatic test_reset_mid_fill();
    int n = 0;
    drive(0, 16'h0, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 16'($urandom), 0, 0, 0);
    reset_n = 0;
    #1;
    checks++;
    if ({s_ready, busy, done, overflow, avm_write, avm_chipselect, avm_clken,
         avm_byteenable, avm_address, wr_count, avm_writedata} !== '0) begin
      errors++; $display("FAIL midreset_outputs ready=%b busy=%b wr=%b clken=%b cnt=%0d exp all 0",
                         s_ready, busy, avm_write, avm_clken, wr_count);
    end
    m_active = 0;
    @(negedge clk);
    reset_n = 1;
    @(posedge clk); #1;
    w_addr.delete(); w_dat.delete(); w_be.delete();
    for (int i = 0; i < 5; i++) drive(1, 16'($urandom), 0, 0, 0);
    checks++;
    if (w_addr.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_quiet writes=%0d busy=%b exp 0/0", w_addr.size(), busy);
    end
    drive(0, 16'h0, 1, 0, 0);
    drive(1, 16'($urandom), 0, 0, 0);
    drive(1, 16'($urandom), 0, 0, 0);
    drive(0, 16'h0, 0, 1, 0);
    while (done !== 1'b1 && n < 10) begin drive(0, 16'h0, 0, 0, 0); n++; end
    build_exp();
    checks++;
    if (w_addr.size() != e_addr.size()) begin errors++; $display("FAIL midreset_nwr got=%0d exp=%0d", w_addr.size(), e_addr.size()); end
    for (int i = 0; i < e_addr.size() && i < w_addr.size(); i++) begin
      checks++;
      if ({w_addr[i], w_dat[i], w_be[i]} !== {e_addr[i], e_dat[i], e_be[i]}) begin
        errors++; $display("FAIL midreset_wr%0d got a=%0d d=%h be=%b exp a=%0d d=%h be=%b",
                           i, w_addr[i], w_dat[i], w_be[i], e_addr[i], e_dat[i], e_be[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 8; it++) begin
      int n = 0;
      int len = $urandom_range(1, 20);
      drive(0, 16'h0, 1, 0, $urandom_range(0, 1) == 1);
      for (int c = 0; c < len && m_active; c++) drive($urandom_range(0, 3) != 0, 16'($urandom), 0, 0, 0);
      if (m_active) drive($urandom_range(0, 1) == 1, 16'($urandom), 0, 1, 0);
      while (done !== 1'b1 && n < 10) begin drive(0, 16'h0, 0, 0, 0); n++; end
      build_exp();
      checks++;
      if (done !== 1'b1 || wr_count !== ADDR_W'(exp_count()) || dut_acc != m_acc.size()) begin
        errors++; $display("FAIL b2b%0d_status done=%b cnt=%0d acc=%0d exp 1/%0d/%0d",
                           it, done, wr_count, dut_acc, exp_count(), m_acc.size());
      end
      checks++;
      if (w_addr.size() != e_addr.size()) begin errors++; $display("FAIL b2b%0d_nwr got=%0d exp=%0d", it, w_addr.size(), e_addr.size()); end
      for (int i = 0; i < e_addr.size() && i < w_addr.size(); i++) begin
        checks++;
        if ({w_addr[i], w_dat[i], w_be[i]} !== {e_addr[i], e_dat[i], e_be[i]}) begin
          errors++; $display("FAIL b2b%0d_wr%0d got a=%0d d=%h be=%b exp a=%0d d=%h be=%b",
                             it, i, w_addr[i], w_dat[i], w_be[i], e_addr[i], e_dat[i], e_be[i]);
        end
      end
    end
    checks++;
    if (cs_bad != 0) begin errors++; $display("FAIL chipselect_follows_write bad_cycles=%0d exp=0", cs_bad); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_oneshot();
    test_stop_mid_word();
    test_stop_with_last();
    test_circular();
    test_overflow();
    test_reset_mid_fill();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
